// File: rtl/pulse_event_capture.sv
// rtl/pulse_event_capture.sv - rising-edge event capture with timestamps and record FIFO
//
// Watches a vector of filtered pulse levels, stamps each enabled rising edge
// with a free-running cycle counter and queues {channel, timestamp} records
// for a valid/ready consumer. Simultaneous edges are serialised lowest
// channel first. Edges that arrive while their channel still holds an
// unqueued event are counted as drops.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   pulse_in       CH filtered pulse levels
//   ch_enable      CH per-channel capture enable
//   ev_valid       head record available
//   ev_ready       consumer accepts head record
//   ev_channel     channel index of head (last popped record when empty)
//   ev_timestamp   timestamp of head (last popped record when empty)
//   overflow       sticky drop flag
//   drop_cnt       saturating count of dropped events
//   clr_overflow   clears overflow and drop_cnt
module pulse_event_capture #(
  parameter int CH    = 32,
  parameter int TS_W  = 32,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   pulse_in,
  input  logic [CH-1:0]   ch_enable,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [4:0]      ev_channel,
  output logic [TS_W-1:0] ev_timestamp,
  output logic            overflow,
  output logic [15:0]     drop_cnt,
  input  logic            clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [TS_W-1:0] ts_cnt;
  logic [CH-1:0]   prev;
  logic [CH-1:0]   pending;
  logic [TS_W-1:0] ts_hold [CH];

  logic [CH-1:0]   rise;
  logic [CH-1:0]   grant_vec;
  logic [CH-1:0]   drop_vec;
  logic [4:0]      grant_idx;
  logic            grant;
  logic [5:0]      ndrop;
  logic [15:0]     drop_base;
  logic [16:0]     drop_sum;

  logic [TS_W+4:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            pop;
  logic            can_accept;
  logic [4:0]      last_ch;
  logic [TS_W-1:0] last_ts;
  logic [TS_W+4:0] head;

  assign rise       = pulse_in & ~prev & ch_enable;
  assign ev_valid   = (count != '0);
  assign pop        = ev_valid && ev_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign can_accept = (count != FULL_CNT) || pop;
  assign grant      = (pending != '0) && can_accept;
  assign grant_vec  = grant ? (CH'(1) << grant_idx) : '0;
  // A channel being granted this cycle frees its slot, so a coincident edge
  // re-arms it instead of being dropped.
  assign drop_vec   = rise & pending & ~grant_vec;
  assign head       = mem[rd_ptr];

  // Fixed-priority pick: scan downwards so the lowest set bit wins.
  always_comb begin
    grant_idx = '0;
    for (int i = CH-1; i >= 0; i--) begin
      if (pending[i]) grant_idx = 5'(i);
    end
  end

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < CH; i++) begin
      ndrop = ndrop + 6'(drop_vec[i]);
    end
    drop_base = clr_overflow ? 16'd0 : drop_cnt;
    drop_sum  = {1'b0, drop_base} + 17'(ndrop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt   <= '0;
      prev     <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      for (int i = 0; i < CH; i++) ts_hold[i] <= '0;
    end else begin
      ts_cnt   <= ts_cnt + TS_W'(1);
      prev     <= pulse_in;
      pending  <= (pending & ~grant_vec) | rise;
      for (int i = 0; i < CH; i++) begin
        if (rise[i] && !drop_vec[i]) ts_hold[i] <= ts_cnt;
      end
      overflow <= (overflow && !clr_overflow) || (drop_vec != '0);
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // Record storage needs no reset: only slots behind wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (grant) mem[wr_ptr] <= {grant_idx, ts_hold[grant_idx]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      last_ch <= '0;
      last_ts <= '0;
    end else begin
      if (grant) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        last_ch <= head[TS_W+4:TS_W];
        last_ts <= head[TS_W-1:0];
      end
      case ({grant, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign ev_channel   = ev_valid ? head[TS_W+4:TS_W] : last_ch;
  assign ev_timestamp = ev_valid ? head[TS_W-1:0]    : last_ts;

endmodule

// File: tb/tb_pulse_event_capture.sv
// tb/tb_pulse_event_capture.sv - directed self-checking bench for pulse_event_capture
module tb_pulse_event_capture;

  localparam int CH   = 32;
  localparam int TS_W = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH-1:0]   pulse_in = '0;
  logic [CH-1:0]   ch_enable = '1;
  logic            ev_ready = 1'b1;
  logic            clr_overflow = 1'b0;
  logic            ev_valid;
  logic [4:0]      ev_channel;
  logic [TS_W-1:0] ev_timestamp;
  logic            overflow;
  logic [15:0]     drop_cnt;

  pulse_event_capture #(.CH(CH), .TS_W(TS_W), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .ch_enable(ch_enable),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_channel(ev_channel),
    .ev_timestamp(ev_timestamp), .overflow(overflow), .drop_cnt(drop_cnt),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  // Bench-side cycle count; at a negedge it equals the timestamp an edge
  // driven there will carry.
  logic [TS_W-1:0] cyc;
  always @(posedge clk) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 8'd1;
  end

  int checks = 0;
  int failures = 0;
  logic [4:0]      exp_ch [17];
  logic [TS_W-1:0] exp_ts [17];
  logic [TS_W-1:0] t5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input logic [TS_W-1:0] v);
    int n;
    n = 0;
    while (cyc !== v && n < 600) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Pops with ev_ready=1, comparing each visible record to the expected list.
  task automatic drain(input int nexp, input string tag);
    int n;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (ev_valid) begin
        if (n < nexp) begin
          chk({tag, "_ch"}, ev_channel, exp_ch[n]);
          chk({tag, "_ts"}, ev_timestamp, exp_ts[n]);
        end
        n++;
      end
      step();
    end
    chk({tag, "_count"}, n, nexp);
  endtask

  initial begin
    step(3);
    chk("rst_valid", ev_valid, 0);
    chk("rst_ch", ev_channel, 0);
    chk("rst_ts", ev_timestamp, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;

    // Single edge: latency and hold-after-pop.
    wait_cyc(8'd10);
    pulse_in[0] = 1'b1;
    step();
    chk("t1_valid_k", ev_valid, 0);
    step();
    chk("t1_valid", ev_valid, 1);
    chk("t1_ch", ev_channel, 0);
    chk("t1_ts", ev_timestamp, 10);
    step();
    chk("t1_valid_after", ev_valid, 0);
    chk("t1_hold_ch", ev_channel, 0);
    chk("t1_hold_ts", ev_timestamp, 10);
    pulse_in = '0;

    // Three simultaneous edges serialised in channel order.
    wait_cyc(8'd20);
    pulse_in = (32'd1 << 3) | (32'd1 << 7) | (32'd1 << 31);
    step();
    chk("t2_valid_k", ev_valid, 0);
    step();
    chk("t2_ch_a", ev_channel, 3);
    chk("t2_ts_a", ev_timestamp, 20);
    step();
    chk("t2_ch_b", ev_channel, 7);
    chk("t2_ts_b", ev_timestamp, 20);
    step();
    chk("t2_valid_c", ev_valid, 1);
    chk("t2_ch_c", ev_channel, 31);
    chk("t2_ts_c", ev_timestamp, 20);
    step();
    chk("t2_valid_end", ev_valid, 0);
    pulse_in = '0;

    // 17 edges against a stalled consumer: 16 queued, one held pending.
    ev_ready = 1'b0;
    step();
    for (int i = 0; i < 17; i++) begin
      exp_ch[i] = 5'(8 + i);
      exp_ts[i] = cyc;
      pulse_in[8 + i] = 1'b1;
      step(2);
    end
    step(2);
    chk("t3_ovf", overflow, 0);
    chk("t3_drop", drop_cnt, 0);
    chk("t3_valid", ev_valid, 1);
    ev_ready = 1'b1;
    drain(17, "t3");
    pulse_in = '0;

    // Full FIFO, ch5 rises three times: first held, two dropped.
    ev_ready = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      exp_ch[i] = 5'(8 + i);
      exp_ts[i] = cyc;
      pulse_in[8 + i] = 1'b1;
      step(2);
    end
    t5 = cyc;
    exp_ch[16] = 5'd5;
    exp_ts[16] = t5;
    pulse_in[5] = 1'b1;
    step();
    pulse_in[5] = 1'b0;
    step();
    pulse_in[5] = 1'b1;
    step();
    chk("t4_ovf_1", overflow, 1);
    chk("t4_drop_1", drop_cnt, 1);
    pulse_in[5] = 1'b0;
    step();
    pulse_in[5] = 1'b1;
    step();
    chk("t4_ovf_2", overflow, 1);
    chk("t4_drop_2", drop_cnt, 2);
    pulse_in[5] = 1'b0;
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("t4_clr_ovf", overflow, 0);
    chk("t4_clr_drop", drop_cnt, 0);
    ev_ready = 1'b1;
    drain(17, "t4");
    pulse_in = '0;

    // Disabled channel ignored; timestamp wrap.
    ch_enable[2] = 1'b0;
    pulse_in[2] = 1'b1;
    step();
    pulse_in[2] = 1'b0;
    step(4);
    chk("t5_disabled", ev_valid, 0);
    ch_enable = '1;
    wait_cyc(8'hFF);
    pulse_in[1] = 1'b1;
    step();
    pulse_in[9] = 1'b1;
    step();
    chk("t5_wrap_valid", ev_valid, 1);
    chk("t5_wrap_ch_a", ev_channel, 1);
    chk("t5_wrap_ts_a", ev_timestamp, 8'hFF);
    step();
    chk("t5_wrap_ch_b", ev_channel, 9);
    chk("t5_wrap_ts_b", ev_timestamp, 8'h00);
    step();
    pulse_in = '0;

    // Reset with 5 queued and 2 pending; ch6 held high through reset.
    ev_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      pulse_in[10 + i] = 1'b1;
      step(2);
    end
    pulse_in[22:20] = 3'b111;
    step(2);
    chk("t6_valid_pre", ev_valid, 1);
    rst = 1'b1;
    pulse_in = 32'h40;
    step();
    chk("t6_rst_valid", ev_valid, 0);
    chk("t6_rst_ch", ev_channel, 0);
    chk("t6_rst_ts", ev_timestamp, 0);
    rst = 1'b0;
    ev_ready = 1'b1;
    exp_ch[0] = 5'd6;
    exp_ts[0] = 8'd0;
    drain(1, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_event_capture.md
# pulse_event_capture

Downstream consumer of the 32-channel pulse glitch filter: watches the filtered `pulse_out` vector, detects rising edges per channel, stamps each with a free-running cycle counter, and queues {channel, timestamp} records in a FIFO drained over a valid/ready interface. Simultaneous edges on several channels are serialised by a fixed-priority arbiter. Lost events are counted, never silently discarded.

## Interface
- `CH`, 32, number of pulse channels (must be ≤ 32; channel index width is 5)
- `TS_W`, 32, timestamp counter width
- `DEPTH`, 16, FIFO depth in records (power of two, ≥ 2)

- `clk`  in  1  single clock for all logic
- `rst`  in  1  synchronous, active-high reset
- `pulse_in`  in  CH  filtered pulse levels from the filter stage
- `ch_enable`  in  CH  per-channel capture enable; 0 = edges on that channel ignored
- `ev_valid`  out  1  FIFO head holds a record
- `ev_ready`  in  1  consumer accepts head record
- `ev_channel`  out  5  channel index of head record
- `ev_timestamp`  out  TS_W  timestamp of head record
- `overflow`  out  1  sticky: at least one event dropped
- `drop_cnt`  out  16  number of dropped events, saturating
- `clr_overflow`  in  1  clears `overflow` and `drop_cnt`

## Operation
- Timestamp counter `ts_cnt`: increments every cycle, wraps 2^TS_W−1 → 0. Reset value 0.
- Edge detect: register `prev` ← `pulse_in` each cycle (reset 0). Rising edge on channel i at edge k when `pulse_in[i]`=1, `prev[i]`=0, `ch_enable[i]`=1.
- On rising edge: `pending[i]` ← 1, `ts_hold[i]` ← `ts_cnt` value present before edge k.
- New edge on channel i while `pending[i]`=1: event dropped; `ts_hold[i]` keeps original value; `overflow` ← 1; `drop_cnt` += 1 (saturates at 0xFFFF).
- Arbiter: each cycle selects lowest-index set bit of `pending`. If FIFO can accept, writes {i, `ts_hold[i]`} and clears `pending[i]`. One write per cycle max.
- Clear-and-set same cycle on same channel cannot occur (edges ≥ 2 cycles apart); if both indicated, set wins.
- FIFO can accept when count < DEPTH, or count = DEPTH and a read occurs the same cycle.
- Read: pop when `ev_valid` && `ev_ready`. `ev_channel`/`ev_timestamp` show head record; when empty they hold the last popped record (0 after reset).
- `ch_enable` deassertion does not flush already-pending events.
- `clr_overflow`: `overflow` ← 0, `drop_cnt` ← 0; if a drop occurs in same cycle, result is `overflow`=1, `drop_cnt`=1.
- Reset: clears `prev`, `pending`, `ts_hold`, `ts_cnt`, FIFO pointers/count, `overflow`, `drop_cnt`; outputs `ev_valid`=0, `ev_channel`=0, `ev_timestamp`=0, `overflow`=0, `drop_cnt`=0. Reset mid-operation discards all pending and queued records; first edge detectable is one seen after `rst` drops relative to `prev`=0 (a channel high during reset produces an edge on the first cycle out of reset if enabled).

## Timing
- Edge sampled at clock edge k → `pending` set at k → FIFO write at k+1 → `ev_valid`=1 in cycle after k+1 (latency 2 cycles, empty FIFO, no contention).
- N simultaneous edges: records written on edges k+1 … k+N in ascending channel order, all carrying the same timestamp.
- `ev_valid` stays high while count > 0; next record visible the cycle after a pop.
- Throughput: one record written and one read per cycle sustained.
- `overflow`, `drop_cnt` update on the clock edge where the drop is detected.

## Test plan
- Reset, `ch_enable`=all 1s, ch0 rises when `ts_cnt`=10, `ev_ready`=1 -> one record {ch 0, ts 10}, `ev_valid` high 1 cycle, appears 2 cycles after sampling edge.
- ch3, ch7, ch31 rise in same cycle at `ts_cnt`=20 -> three records, order 3,7,31, all ts 20, on consecutive cycles.
- `ev_ready`=0, 17 distinct single-channel edges (DEPTH=16, spaced so pending clears) -> 16 records queued, 17th held in `pending`; raise `ev_ready` -> all 17 delivered in order, no drop.
- `ev_ready`=0, FIFO full, ch5 toggles 3 rising edges -> first held pending, next two dropped: `overflow`=1, `drop_cnt`=2, delivered ch5 record carries first timestamp; `clr_overflow` pulse -> `overflow`=0, `drop_cnt`=0.
- `ch_enable[2]`=0, ch2 pulses -> no record; counter near wrap (`ts_cnt`=0xFFFFFFFF at sampling) -> record ts 0xFFFFFFFF, next edge 1 cycle later shows ts 0x00000000 region.
- Assert `rst` with 5 records queued and 2 pending -> next cycle `ev_valid`=0, outputs 0; after release no stale records emerge.
